// File: rtl/fifo_rr_arbiter.sv
//------------------------------------------------------------------------------
// fifo_rr_arbiter: drains four upstream FIFOs into one downstream FIFO.
// Optional macro ARB_STRICT_PRIO_EN selects fixed priority instead of round-robin.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          buf_empty_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] buf_out_in,
    input  logic                       out_almost_full,
    input  logic                       out_full,
    output logic [NUM_CH-1:0]          rd_en,
    output logic                       wr_en,
    output logic [DATA_WIDTH-1:0]      buf_out,
    output logic [1:0]                 ch_sel,
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NUM_CH-1:0]      r_rd_en;
    logic                   r_v1;
    logic [1:0]             r_ch1;
    logic                   r_wr_en;
    logic [DATA_WIDTH-1:0]  r_buf_out;
    logic [1:0]             r_ch_sel;

    logic [NUM_CH-1:0]      w_elig;
    logic                   w_any;
    logic                   w_pause;
    logic                   w_grant_ok;
    logic [1:0]             w_gnt_idx;
    logic [1:0]             w_rd_idx;

    // A channel popped last cycle still shows its pre-pop empty flag.
    assign w_elig  = ~buf_empty_in & ~r_rd_en;
    assign w_any   = |w_elig;
    assign w_pause = out_almost_full | out_full;
    assign w_rd_idx = {r_rd_en[3] | r_rd_en[2], r_rd_en[3] | r_rd_en[1]};

    always_comb begin
        w_next_state = r_state;
        w_grant_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pause) begin
                    w_next_state = PAUSE;
                end else if (w_any) begin
                    w_next_state = RUN;
                    w_grant_ok   = 1'b1;
                end
            end
            RUN: begin
                if (w_pause) begin
                    w_next_state = PAUSE;
                end else if (w_any) begin
                    w_grant_ok = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            PAUSE: begin
                if (!w_pause) begin
                    w_next_state = w_any ? RUN : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef ARB_STRICT_PRIO_EN
    always_comb begin
        w_gnt_idx = 2'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_gnt_idx = 2'(k);
            end
        end
    end
`else
    logic [1:0] r_ptr;
    logic [1:0] w_cand;
    logic       w_found;

    // Search begins one past the last granted channel.
    always_comb begin
        w_gnt_idx = r_ptr;
        w_found   = 1'b0;
        w_cand    = r_ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 2'd3;
        end else if (w_grant_ok) begin
            r_ptr <= w_gnt_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_rd_en   <= '0;
            r_v1      <= 1'b0;
            r_ch1     <= 2'd0;
            r_wr_en   <= 1'b0;
            r_buf_out <= '0;
            r_ch_sel  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_rd_en <= '0;
            if (w_grant_ok) begin
                r_rd_en[w_gnt_idx] <= 1'b1;
            end
            // Upstream data appears one cycle after the pop strobe.
            r_v1    <= |r_rd_en;
            r_ch1   <= w_rd_idx;
            r_wr_en <= r_v1;
            if (r_v1) begin
                r_buf_out <= buf_out_in[r_ch1*DATA_WIDTH +: DATA_WIDTH];
                r_ch_sel  <= r_ch1;
            end
        end
    end

    assign rd_en   = r_rd_en;
    assign wr_en   = r_wr_en;
    assign buf_out = r_buf_out;
    assign ch_sel  = r_ch_sel;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of each data lane.
REQ-002 SHALL have parameter NUM_CH, fixed at 4, number of upstream fifo8 instances drained.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port buf_empty_in, input, NUM_CH, buf_empty flags of upstream FIFOs, bit i = channel i.
REQ-006 SHALL have port buf_out_in, input, NUM_CH*DATA_WIDTH, upstream buf_out lanes, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port out_almost_full, input, 1, almost_full of downstream FIFO.
REQ-008 SHALL have port out_full, input, 1, buf_full of downstream FIFO.
REQ-009 SHALL have port rd_en, output, NUM_CH, registered one-hot (or zero) pop strobe to upstream FIFOs.
REQ-010 SHALL have port wr_en, output, 1, registered push strobe to downstream FIFO.
REQ-011 SHALL have port buf_out, output, DATA_WIDTH, registered data to downstream buf_in.
REQ-012 SHALL have port ch_sel, output, 2, channel index of the word on buf_out.
REQ-013 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-014 FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 unused, returns to IDLE.
REQ-015 IDLE->RUN when any channel eligible; RUN->IDLE when none eligible; any state->PAUSE when out_almost_full or out_full is 1; PAUSE->RUN/IDLE only when both are 0.
REQ-016 Channel eligible = buf_empty_in[i]==0 AND i not granted in the immediately preceding cycle (stale-flag guard).
REQ-017 Grant issued only in RUN or on the IDLE->RUN cycle, never in PAUSE: rd_en[i]=1 for exactly one cycle.
REQ-018 Round-robin: search starts at (last granted + 1) mod 4; pointer updates only on a grant; pointer reset value 3, so channel 0 wins first.
REQ-019 Pipeline: rd_en[i] high in cycle N; buf_out_in lane i sampled at edge ending N+1; wr_en=1, buf_out, ch_sel=i valid in cycle N+2.
REQ-020 Throughput: one grant per cycle across channels; one grant per two cycles for a single channel.
REQ-021 wr_en is never 1 unless a rd_en was issued exactly two cycles earlier; in-flight words (max 2) complete even if PAUSE is entered.
REQ-022 out_almost_full downstream threshold SHALL be set >= 2 free slots; arbiter relies on it to absorb in-flight words.
REQ-023 buf_out and ch_sel hold their last value when wr_en=0.

Reset
REQ-024 rst=0 asynchronously forces rd_en=0, wr_en=0, buf_out=0, ch_sel=0, state=IDLE, pointer=3, pipeline valids=0.
REQ-025 Reset mid-transfer drops in-flight words; no wr_en for them after rst returns to 1.
REQ-026 First grant possible in the first clock cycle after rst deasserts.

Configuration
REQ-027 Macro ARB_STRICT_PRIO_EN defined: fixed priority, channel 0 highest, channel 3 lowest; pointer unused, stale-flag guard still applies.
REQ-028 Macro ARB_STRICT_PRIO_EN undefined: round-robin per REQ-018.

Verification
REQ-029 Reset: rst=0 with all inputs random -> all outputs 0, state=00; release with all empty -> stays IDLE, no strobes.
REQ-030 Channels 0-3 each hold 2 words (ch i holds 4'h1+i, 4'h5+i), no backpressure -> rd_en 0001,0010,0100,1000,0001,...; wr_en data 1,2,3,4,5,6,7,8 with ch_sel 0,1,2,3,0,1,2,3, first wr_en 2 cycles after first rd_en.
REQ-031 Only channel 2 non-empty with 3 words -> rd_en[2] every other cycle, never back-to-back; 3 writes, then IDLE.
REQ-032 out_almost_full=1 while 2 grants in flight -> state=PAUSE, no new rd_en, both in-flight words written; deassert -> RUN resumes at next channel in rotation.
REQ-033 rst=0 pulse one cycle after rd_en[1] -> no wr_en for that word, pointer back to 3, first grant after release goes to channel 0 if non-empty.
REQ-034 With ARB_STRICT_PRIO_EN, channels 0 and 3 non-empty (3 words each) -> grants 0,3,0,3,0,3 (guard alternates), channel 0 data written first.
